mdu: RTL and testbench

- Execute-stage multiply/divide unit, sibling of the E-stage ALU.
- Consumes the same forwarded operands (rs → A, rt → B) and owns the HI/LO register pair.
- Implements mult, multu, div, divu, mthi, mtlo, mfhi, mflo with fixed multi-cycle latency.
- The hazard unit stalls on busy|start.
- mdu_out is muxed with the ALU result into the E/M pipeline register.

---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_calc.sv | 98 +++++++++
 rtl/mdu.sv | 125 ++++++++++++
 tb/tb_mdu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation
// encodings, default latencies, FSM states and op-class helpers.
// Optional macro MDU_MADD_EN adds the multiply-accumulate op class.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ops that occupy the unit for the multiply latency.
  function automatic logic is_mult_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB);
`endif
    return r;
  endfunction

  // Ops that occupy the unit for the divide latency.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core of the multiply/divide unit. Produces the
// 64-bit {hi,lo} result for the op on its inputs plus a write-enable that
// drops on divide-by-zero so HI/LO keep their old contents.
// Macro MDU_MADD_EN enables madd/maddu/msub accumulate paths.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        we
);

  // Two's-complement negate when requested; restores sign after magnitude divide.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic signed [63:0] sa, sb, sprod;
  logic        [63:0] uprod;
  logic        [31:0] ma, mb, b_nz, mb_nz;
  logic        [31:0] uq, ur, mq, mr;
  logic               b_zero;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`else
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  // Products and quotients for every op class, then select by op.
  always_comb begin
    sa     = {{32{a[31]}}, a};
    sb     = {{32{b[31]}}, b};
    sprod  = sa * sb;
    uprod  = {32'd0, a} * {32'd0, b};

    // Divisor of zero is replaced by one so the datapath never divides by
    // zero; the result is discarded through we=0 in that case.
    b_zero = (b == 32'd0);
    b_nz   = b_zero ? 32'd1 : b;
    uq     = a / b_nz;
    ur     = a % b_nz;

    // Signed divide works on magnitudes; quotient sign is the XOR of the
    // operand signs, remainder follows the dividend. 0x80000000 / -1 wraps.
    ma     = neg_if(a[31], a);
    mb     = neg_if(b[31], b);
    mb_nz  = b_zero ? 32'd1 : mb;
    mq     = ma / mb_nz;
    mr     = ma % mb_nz;

    res = 64'd0;
    we  = 1'b0;
    case (mdu_op)
      OP_MULT: begin
        res = sprod;
        we  = 1'b1;
      end
      OP_MULTU: begin
        res = uprod;
        we  = 1'b1;
      end
      OP_DIV: begin
        res = {neg_if(a[31], mr), neg_if(a[31] ^ b[31], mq)};
        we  = ~b_zero;
      end
      OP_DIVU: begin
        res = {ur, uq};
        we  = ~b_zero;
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        res = acc + sprod;
        we  = 1'b1;
      end
      OP_MADDU: begin
        res = acc + uprod;
        we  = 1'b1;
      end
      OP_MSUB: begin
        res = acc - sprod;
        we  = 1'b1;
      end
`endif
      default: begin
        res = 64'd0;
        we  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit. Launches mult/div-class ops on a start
// pulse, holds busy for a fixed latency, then commits the captured result
// to HI/LO. mthi/mtlo write directly when idle; mfhi/mflo read via mdu_out.
// Macro MDU_MADD_EN enables madd/maddu/msub (multiply latency).
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      calc_res;
  logic             calc_we;
  logic             launch, finish, wr_hi, wr_lo;

  // Result captured at launch, committed to HI/LO at completion.
  logic [63:0]      temp_p0;
  logic             vld_p0;

  mdu_calc u_calc (
    .mdu_op (mdu_op),
    .a      (A),
    .b      (B),
    .hi     (hi),
    .lo     (lo),
    .res    (calc_res),
    .we     (calc_we)
  );

  assign busy = (state == RUN);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle strobes. req flushes the E-stage instruction,
  // so it blocks launch and mthi/mtlo but never an op already running.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    finish    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (!req) begin
          if (start && (is_mult_op(mdu_op) || is_div_op(mdu_op))) begin
            launch    = 1'b1;
            state_nxt = RUN;
          end else begin
            wr_hi = (mdu_op == OP_MTHI);
            wr_lo = (mdu_op == OP_MTLO);
          end
        end
      end
      RUN: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter: loaded with latency-1 at launch, counts down in RUN.
  always_ff @(posedge clk) begin
    if (reset)                          cnt <= '0;
    else if (launch)                    cnt <= is_div_op(mdu_op) ? DIV_LAT : MULT_LAT;
    else if (busy && (cnt != '0))       cnt <= cnt - CNT_W'(1);
  end

  // ---- stage p0: result capture at launch (data, no reset) ----
  always_ff @(posedge clk) begin
    if (launch) begin
      temp_p0 <= calc_res;
      vld_p0  <= calc_we;
    end
  end

  // HI/LO update: completion commit has priority; mthi/mtlo only when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (finish) begin
      if (vld_p0) begin
        hi <= temp_p0[63:32];
        lo <= temp_p0[31:0];
      end
    end else begin
      if (wr_hi) hi <= A;
      if (wr_lo) lo <= A;
    end
  end

  // Combinational mfhi/mflo read path.
  always_comb begin
    mdu_out = 32'd0;
    if (mdu_op == OP_MFHI)      mdu_out = hi;
    else if (mdu_op == OP_MFLO) mdu_out = lo;
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors, an arithmetic reference
// model of HI/LO/busy compared every cycle, and literal expectations.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, req;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo, mdu_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_op  (mdu_op),
    .A       (A),
    .B       (B),
    .req     (req),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mdu_out (mdu_out)
  );

  // Reference model state
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;
  logic        m_we = 1'b0;
  int          m_left = 0;
  bit          started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_is_md(input logic [3:0] op);
    bit r;
    r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB);
`endif
    return r;
  endfunction

  // {we, hi, lo} the op must produce, from plain 64-bit arithmetic
  function automatic logic [64:0] model_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = 64'd0;
    case (op)
      OP_MULT:  return {1'b1, 64'(sa * sb)};
      OP_MULTU: begin v = {32'd0, a} * {32'd0, b}; return {1'b1, v}; end
      OP_DIV: begin
        if (b == 32'd0) return 65'd0;
        q = sa / sb;
        r = sa % sb;
        v = {r[31:0], q[31:0]};
        return {1'b1, v};
      end
      OP_DIVU: begin
        if (b == 32'd0) return 65'd0;
        v = {a % b, a / b};
        return {1'b1, v};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin v = {h, l} + 64'(sa * sb); return {1'b1, v}; end
      OP_MADDU: begin v = {h, l} + {32'd0, a} * {32'd0, b}; return {1'b1, v}; end
      OP_MSUB:  begin v = {h, l} - 64'(sa * sb); return {1'b1, v}; end
`endif
      default: return 65'd0;
    endcase
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge
  task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic rq, input logic rs);
    if (rs) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_we) {m_hi, m_lo} = m_res;
    end else if (s && !rq && model_is_md(op)) begin
      {m_we, m_res} = model_calc(op, a, b, m_hi, m_lo);
      m_left = (op == OP_DIV || op == OP_DIVU) ? 10 : 5;
    end else if (!rq && op == OP_MTHI) begin
      m_hi = a;
    end else if (!rq && op == OP_MTLO) begin
      m_lo = a;
    end
  endtask

  task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic rq, input logic rs);
    mdu_op = op; A = a; B = b; start = s; req = rq; reset = rs;
    @(posedge clk);
    model_edge(op, a, b, s, rq, rs);
    #1;
    started = 1'b1;
  endtask

  task automatic idle();
    cyc(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Count busy cycles from just after launch, with an optional illegal
  // restart on the second busy cycle; bounded.
  task automatic run_busy(input bit restart, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (restart && n == 2) cyc(OP_MULT, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
      else idle();
    end
  endtask

  // Every-cycle comparison of the DUT against the model
  initial begin
    logic [31:0] exp_out;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_out = (mdu_op == OP_MFHI) ? m_hi : (mdu_op == OP_MFLO) ? m_lo : 32'd0;
        chk("cyc_busy", {31'd0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
        chk("cyc_mdu_out", mdu_out, exp_out);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cyc(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cyc(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    idle();

    // MULT -3 * 7
    cyc(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, 1'b0);
    run_busy(1'b0, n);
    chk("mult_busy_len", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    // MULTU 0xFFFFFFFF * 2
    cyc(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 1'b0);
    run_busy(1'b0, n);
    chk("multu_busy_len", n, 32'd5);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // Same MULTU with an illegal second start while busy
    cyc(OP_MTHI, 32'hAAAA0000, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 1'b0);
    run_busy(1'b1, n);
    chk("restart_busy_len", n, 32'd5);
    chk("restart_hi", hi, 32'h00000001);
    chk("restart_lo", lo, 32'hFFFFFFFE);

    // DIV -7 / 2, DIVU 7 / 2
    cyc(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    run_busy(1'b0, n);
    chk("div_busy_len", n, 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    cyc(OP_DIVU, 32'd7, 32'd2, 1'b1, 1'b0, 1'b0);
    run_busy(1'b0, n);
    chk("divu_busy_len", n, 32'd10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // Divide by zero leaves preloaded HI/LO alone
    cyc(OP_MTHI, 32'h11, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(OP_MTLO, 32'h22, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(OP_DIV, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
    run_busy(1'b0, n);
    chk("divz_busy_len", n, 32'd10);
    chk("divz_hi", hi, 32'h11);
    chk("divz_lo", lo, 32'h22);

    // mthi then mfhi / mflo reads
    cyc(OP_MTHI, 32'h12345678, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("mfhi_out", mdu_out, 32'h12345678);
    cyc(OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("mflo_out", mdu_out, 32'h22);

    // Flushed start and flushed mtlo are ignored
    cyc(OP_MULT, 32'd2, 32'd3, 1'b1, 1'b1, 1'b0);
    chk("req_mult_busy", {31'd0, busy}, 32'd0);
    idle();
    chk("req_mult_hi", hi, 32'h12345678);
    chk("req_mult_lo", lo, 32'h22);
    cyc(OP_MTLO, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("req_mtlo_lo", lo, 32'h22);

    // Unknown encoding with start does nothing
    cyc(4'd13, 32'd4, 32'd4, 1'b1, 1'b0, 1'b0);
    chk("unknown_busy", {31'd0, busy}, 32'd0);
    idle();

    // req during a running op does not abort it
    cyc(OP_MULTU, 32'd6, 32'd7, 1'b1, 1'b0, 1'b0);
    cyc(OP_MTHI, 32'h55, 32'd0, 1'b1, 1'b1, 1'b0);
    run_busy(1'b0, n);
    chk("req_run_lo", lo, 32'd42);
    chk("req_run_hi", hi, 32'd0);

    // Reset in the third busy cycle of a DIV aborts it
    cyc(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    cyc(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) idle();
    chk("rstmid_late_hi", hi, 32'd0);
    chk("rstmid_late_lo", lo, 32'd0);

`ifdef MDU_MADD_EN
    cyc(OP_MTHI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(OP_MTLO, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(OP_MADD, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
    run_busy(1'b0, n);
    chk("madd_busy_len", n, 32'd5);
    chk("madd_lo", lo, 32'd17);
    chk("madd_hi", hi, 32'd0);
    cyc(OP_MSUB, 32'd3, 32'd6, 1'b1, 1'b0, 1'b0);
    run_busy(1'b0, n);
    chk("msub_lo", lo, 32'hFFFFFFFF);
    chk("msub_hi", hi, 32'hFFFFFFFF);
`else
    cyc(OP_MADD, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    idle();
    chk("madd_off_lo", lo, 32'd0);
`endif

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
